add_64_seq: RTL and testbench

Multi-cycle wide adder/subtractor that feeds 64-bit operands, 16 bits per cycle, through a single instance of the team's 16-bit carry-lookahead adder (`CLA_16_bit_ripple`). It registers the inter-chunk carry and assembles the full result. It sits directly upstream of that adder and wraps it in a valid/ready handshake. This lets datapath stages perform wide arithmetic without instantiating four adder slices.

---
 rtl/add64_seq_pkg.sv | 12 +
 rtl/add_64_seq_cla.sv | 42 ++++
 rtl/add_64_seq.sv | 131 +++++++++++++
 tb/tb_add_64_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/add64_seq_pkg.sv
// Shared constants and state encoding for the multi-cycle wide adder.
package add64_seq_pkg;

    localparam int unsigned CHUNK_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage : add64_seq_pkg

// File: rtl/add_64_seq_cla.sv
// 16-bit adder built from four 4-bit carry-lookahead groups, group carries rippled.
module CLA_16_bit_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic       carry;
    logic [4:0] grp_res;

    // One 4-bit lookahead group: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Ripple the group carry through the four lookahead groups.
    always_comb begin
        carry   = c_in;
        sum     = '0;
        grp_res = '0;
        for (int g = 0; g < 4; g++) begin
            grp_res        = cla4(a[4*g +: 4], b[4*g +: 4], carry);
            sum[4*g +: 4]  = grp_res[3:0];
            carry          = grp_res[4];
        end
        c_out = carry;
    end

endmodule : CLA_16_bit_ripple

// File: rtl/add_64_seq.sv
// Wide add/subtract that streams operands through one 16-bit adder, a chunk per cycle.
module add_64_seq
    import add64_seq_pkg::*;
#(
    parameter int unsigned NUM_CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] b,
    input  logic                          c_in,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] sum,
    output logic                          c_out,
    output logic                          overflow
);

    localparam int unsigned W     = CHUNK_W * NUM_CHUNKS;
    localparam int unsigned IDX_W = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_e state_q;
    state_e state_d;

    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       sum_q;
    logic               c_out_q;
    logic               overflow_q;

    logic [CHUNK_W-1:0] a_chunk_c;
    logic [CHUNK_W-1:0] b_chunk_c;
    logic [CHUNK_W-1:0] sum_chunk_c;
    logic               chunk_cout_c;
    logic               accept_c;
    logic               last_c;
    logic               msb_cin_c;

    // Chunk select feeding the single shared adder slice.
    assign a_chunk_c = a_q[CHUNK_W*32'(idx_q) +: CHUNK_W];
    assign b_chunk_c = b_q[CHUNK_W*32'(idx_q) +: CHUNK_W];

    CLA_16_bit_ripple u_cla (
        .a     (a_chunk_c),
        .b     (b_chunk_c),
        .c_in  (carry_q),
        .sum   (sum_chunk_c),
        .c_out (chunk_cout_c)
    );

    assign accept_c  = in_valid && in_ready;
    assign last_c    = (idx_q == LAST_IDX);
    // Carry entering the sign bit, recovered from the sign-bit sum.
    assign msb_cin_c = a_chunk_c[CHUNK_W-1] ^ b_chunk_c[CHUNK_W-1] ^ sum_chunk_c[CHUNK_W-1];

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand capture, chunk carry register and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            sum_q      <= '0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept_c) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            sum_q[CHUNK_W*32'(idx_q) +: CHUNK_W] <= sum_chunk_c;
            carry_q <= chunk_cout_c;
            if (last_c) begin
                c_out_q    <= chunk_cout_c;
                overflow_q <= msb_cin_c ^ chunk_cout_c;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule : add_64_seq

// File: tb/tb_add_64_seq.sv
// Randomized and directed checks of add_64_seq against a plain-arithmetic model.
module tb_add_64_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        c_out;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    add_64_seq #(.NUM_CHUNKS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact 65-bit arithmetic, signed overflow from operand/result signs.
    task automatic model(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic s,
                         output logic [63:0] r, output logic co, output logic ov);
        logic [64:0] full;
        logic [63:0] y_eff;
        y_eff = s ? ~y : y;
        full  = {1'b0, x} + {1'b0, y_eff} + 65'(s ? 1'b1 : ci);
        r     = full[63:0];
        co    = full[64];
        if (s) ov = (x[63] != y[63]) && (r[63] != x[63]);
        else   ov = (x[63] == y[63]) && (r[63] != x[63]);
    endtask

    // Issue one operation from IDLE (called #1 after a rising edge); hold = cycles of backpressure.
    task automatic do_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic ci, input logic s, input int hold);
        logic [63:0] er;
        logic        eco;
        logic        eov;
        int          lat;
        model(x, y, ci, s, er, eco, eov);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = x; b = y; c_in = ci; sub = s;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd4);
        check_eq({tag, "_sum"}, sum, er);
        check_eq({tag, "_c_out"}, 64'(c_out), 64'(eco));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(eov));
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                @(posedge clk); #1;
                check_eq({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
                check_eq({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
                check_eq({tag, "_bp_sum"}, sum, er);
                check_eq({tag, "_bp_flags"}, {62'd0, c_out, overflow}, {62'd0, eco, eov});
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_eq({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        #12;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", sum, 64'd0);
        check_eq("rst_flags", {62'd0, c_out, overflow}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("carry_chain", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0);
        do_op("full_prop", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0);
        do_op("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 0);
        do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
        do_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0);
        do_op("sub_cin_ignored", 64'd100, 64'd100, 1'b1, 1'b1, 0);
        do_op("backpressure", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 10);

        // Reset while the third chunk is in flight.
        a = 64'hDEAD_BEEF_0000_0001; b = 64'h1111_2222_3333_4444; c_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_sum", sum, 64'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_rst", 64'd3, 64'd4, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 5 == 1) rb = ra;
            if (n % 7 == 2) ra = 64'h8000_0000_0000_0000 ^ 64'($urandom_range(0, 3));
            do_op("rand", ra, rb, 1'($urandom), 1'($urandom), (n % 4 == 3) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_add_64_seq
